dnn_run_sequencer: RTL and testbench
====================================

Name: dnn_run_sequencer

Overview:
- Upstream control stage for the DNN accelerator handshake driver: issues ap_start, tracks ap_ready/ap_done, collects per-run classification results.
- Runs NUM_RUNS back-to-back inferences with programmable guard delays, with a watchdog timeout.
- Measures start-to-done latency (last/min/max) and re-emits each classified label with its run index to downstream logging logic.

Parameters:
- START_DELAY, 100, cycles between enable and the first ap_start.
- END_DELAY, 500, guard cycles after each result before the next start.
- NUM_RUNS, 10, inferences per session; 0 = run until abort.
- TIMEOUT, 1000000, max cycles in any wait state before error.
- LBL_W, 5, label width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous reset, active-high
- i_enable  in  1  session request (level); rising edge starts a session
- i_abort  in  1  single-cycle abort request
- o_ap_start  out  1  accelerator start, held until ready is seen
- i_ap_ready  in  1  accelerator accepted start
- i_ap_done  in  1  accelerator finished (1-cycle pulse)
- i_ap_idle  in  1  accelerator idle
- i_max_v  in  1  result valid pulse from the handshake driver
- i_max_lbl  in  LBL_W  winning label
- o_res_v  out  1  1-cycle result pulse
- o_res_lbl  out  LBL_W  captured label
- o_res_idx  out  16  run index of result (0-based)
- o_last_lat  out  32  latency of last run
- o_min_lat  out  32  min latency this session
- o_max_lat  out  32  max latency this session
- o_busy  out  1  session in progress
- o_done  out  1  session completed normally (sticky)
- o_timeout  out  1  watchdog fired (sticky)

Behaviour:
- Reset values:
  - All outputs 0, except o_min_lat = 32'hFFFF_FFFF.
  - Internal run counter 0; FSM in IDLE.
- States: IDLE, PRE_DLY, START, WAIT_DONE, WAIT_RES, POST_DLY, FINISH, DRAIN, ERR.
- IDLE:
  - Rising edge of i_enable (registered previous value) -> PRE_DLY.
  - On the same edge: clear o_done/o_timeout, run counter, and min/max; set o_busy.
- PRE_DLY: counts START_DELAY cycles, then -> START.
  - START_DELAY = 0 goes to START on the next cycle.
- START:
  - o_ap_start = 1.
  - Latency counter zeroed on entry, increments every cycle until done.
  - Stay until i_ap_ready = 1; o_ap_start drops the cycle after ready is sampled.
  - Then -> WAIT_DONE, or -> WAIT_RES if i_ap_done is high in the same cycle as ready.
- WAIT_DONE:
  - On i_ap_done: o_last_lat <= latency (inclusive of the done cycle); update min/max.
  - Then -> WAIT_RES.
- Latency counter saturates at 32'hFFFF_FFFF.
- WAIT_RES:
  - On i_max_v, in the same clock: o_res_v pulses for 1 cycle, o_res_lbl <= i_max_lbl, o_res_idx <= run counter.
  - Run counter increments; then -> POST_DLY.
  - i_max_v outside WAIT_RES is ignored.
- POST_DLY: counts END_DELAY cycles, then:
  - -> FINISH if NUM_RUNS != 0 and run counter == NUM_RUNS.
  - Otherwise -> START.
- FINISH:
  - o_done = 1, o_busy = 0.
  - -> IDLE when i_enable = 0.
  - o_done stays set until the next session start.
- Watchdog:
  - Cycle counter, cleared on every state entry, active in START, WAIT_DONE and WAIT_RES.
  - Reaching TIMEOUT -> ERR: o_timeout = 1, o_ap_start = 0, o_busy = 0.
  - ERR -> IDLE when i_enable = 0.
- i_abort (priority over every other transition in the same cycle):
  - From PRE_DLY or POST_DLY -> IDLE.
  - From START, WAIT_DONE or WAIT_RES -> DRAIN: o_ap_start = 0, wait for i_ap_idle = 1, then -> IDLE.
  - o_busy clears on IDLE entry.
  - Ignored in IDLE, FINISH and ERR.
  - DRAIN also has watchdog -> ERR.
- Run counter: 16 bits; wraps at 65535 when NUM_RUNS = 0.
- Reset mid-operation returns to IDLE immediately, all outputs at reset values. A still-high i_enable does not restart the block; a new rising edge is required.

Decomposition:
- Package dnn_seq_pkg:
  - State enum seq_state_t.
  - Constants LAT_W = 32, IDX_W = 16, LAT_SAT.
- Sub-module dnn_lat_stats: latency counter with saturation plus last/min/max registers.
  - Ports: clear, run, capture, outputs.
  - Instantiated once.

Test Plan:
- Single run, NUM_RUNS=1, START_DELAY=4, END_DELAY=3; model asserts ready 2 cycles after start, done 20 cycles later, max_v lbl=7 5 cycles after done -> o_ap_start high exactly 3 cycles; o_last_lat = 23; o_res_v pulse with lbl=7, idx=0; o_done high.
- NUM_RUNS=3, done latencies 10/30/20 -> o_min_lat = 10, o_max_lat = 30, o_last_lat = 20; results idx 0,1,2; exactly 3 ap_start assertions.
- Ready and done in the same cycle -> FSM skips WAIT_DONE; o_last_lat = 1; result still captured on the next max_v.
- TIMEOUT=50, model never asserts done -> o_timeout = 1 at cycle 50 in WAIT_DONE; o_ap_start = 0; no o_res_v.
- Abort in WAIT_DONE with i_ap_idle held low 8 cycles -> stays in DRAIN 8 cycles, o_busy drops on IDLE entry; a later i_max_v produces no o_res_v.
- aresetn pulse mid-WAIT_RES with i_enable held high -> all outputs at reset values; no new start until i_enable toggles 0 -> 1.

Source files
------------

// File: rtl/dnn_seq_pkg.sv
// Shared types and constants for the DNN run sequencer: FSM states, counter
// widths and the saturating latency increment.
package dnn_seq_pkg;

  localparam int LAT_W = 32;
  localparam int IDX_W = 16;
  localparam logic [LAT_W-1:0] LAT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PRE_DLY   = 4'd1,
    ST_START     = 4'd2,
    ST_WAIT_DONE = 4'd3,
    ST_WAIT_RES  = 4'd4,
    ST_POST_DLY  = 4'd5,
    ST_FINISH    = 4'd6,
    ST_DRAIN     = 4'd7,
    ST_ERR       = 4'd8
  } seq_state_t;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (v == LAT_SAT) ? LAT_SAT : v + 32'd1;
  endfunction

endpackage

// File: rtl/dnn_lat_stats.sv
// Start-to-done latency counter (saturating) with last/min/max capture.
// The captured value includes the cycle in which capture_i is high.
module dnn_lat_stats
  import dnn_seq_pkg::*;
(
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             sess_clr_i,
  input  logic             cnt_clr_i,
  input  logic             run_i,
  input  logic             capture_i,
  output logic [LAT_W-1:0] last_o,
  output logic [LAT_W-1:0] min_o,
  output logic [LAT_W-1:0] max_o
);

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] min_q, min_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [LAT_W-1:0] cap_s;

  assign cap_s = sat_inc(cnt_q);

  // Next-state for the counter and the statistics registers.
  always_comb begin
    cnt_d  = cnt_clr_i ? 32'd0 : (run_i ? cap_s : cnt_q);
    last_d = capture_i ? cap_s : last_q;
    if (sess_clr_i) begin
      min_d = LAT_SAT;
      max_d = 32'd0;
    end else if (capture_i) begin
      min_d = (cap_s < min_q) ? cap_s : min_q;
      max_d = (cap_s > max_q) ? cap_s : max_q;
    end else begin
      min_d = min_q;
      max_d = max_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      cnt_q  <= 32'd0;
      last_q <= 32'd0;
      min_q  <= LAT_SAT;
      max_q  <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign last_o = last_q;
  assign min_o  = min_q;
  assign max_o  = max_q;

endmodule

// File: rtl/dnn_run_sequencer.sv
// Session sequencer for the DNN accelerator: issues ap_start per run, times each
// inference, forwards classified labels and guards every wait with a watchdog.
module dnn_run_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned END_DELAY   = 500,
  parameter int unsigned NUM_RUNS    = 10,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned LBL_W       = 5
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_enable,
  input  logic             i_abort,
  output logic             o_ap_start,
  input  logic             i_ap_ready,
  input  logic             i_ap_done,
  input  logic             i_ap_idle,
  input  logic             i_max_v,
  input  logic [LBL_W-1:0] i_max_lbl,
  output logic             o_res_v,
  output logic [LBL_W-1:0] o_res_lbl,
  output logic [IDX_W-1:0] o_res_idx,
  output logic [LAT_W-1:0] o_last_lat,
  output logic [LAT_W-1:0] o_min_lat,
  output logic [LAT_W-1:0] o_max_lat,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  seq_state_t       state_q, state_d;
  logic             en_prev_q;
  logic [31:0]      tmr_q, tmr_d;
  logic [IDX_W-1:0] run_q, run_d;
  logic             res_v_q, res_v_d;
  logic [LBL_W-1:0] res_lbl_q, res_lbl_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic             ap_start_q, ap_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic rise_s, sess_start_s, tmr_run_s, pre_hit_s, post_hit_s, wd_hit_s, last_run_s;
  logic res_fire_s, lat_clr_s, lat_run_s, lat_cap_s;

  // One timer serves the guard delays and the watchdog; it restarts on every state entry.
  assign rise_s       = i_enable & ~en_prev_q;
  assign sess_start_s = (state_q == ST_IDLE) & rise_s;
  assign tmr_run_s    = state_q inside {ST_PRE_DLY, ST_START, ST_WAIT_DONE,
                                        ST_WAIT_RES, ST_POST_DLY, ST_DRAIN};
  assign pre_hit_s    = (tmr_q + 32'd1) >= 32'(START_DELAY);
  assign post_hit_s   = (tmr_q + 32'd1) >= 32'(END_DELAY);
  assign wd_hit_s     = (tmr_q + 32'd1) >= 32'(TIMEOUT);
  assign last_run_s   = (32'(NUM_RUNS) != 32'd0) && (run_q == 16'(NUM_RUNS));

  // Session FSM; abort outranks the watchdog, which outranks normal progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = rise_s ? ST_PRE_DLY : ST_IDLE;
      ST_PRE_DLY:   state_d = i_abort ? ST_IDLE : (pre_hit_s ? ST_START : ST_PRE_DLY);
      ST_START: begin
        if (i_abort)         state_d = ST_DRAIN;
        else if (wd_hit_s)   state_d = ST_ERR;
        else if (i_ap_ready) state_d = i_ap_done ? ST_WAIT_RES : ST_WAIT_DONE;
        else                 state_d = ST_START;
      end
      ST_WAIT_DONE: begin
        if (i_abort)        state_d = ST_DRAIN;
        else if (wd_hit_s)  state_d = ST_ERR;
        else if (i_ap_done) state_d = ST_WAIT_RES;
        else                state_d = ST_WAIT_DONE;
      end
      ST_WAIT_RES: begin
        if (i_abort)       state_d = ST_DRAIN;
        else if (wd_hit_s) state_d = ST_ERR;
        else if (i_max_v)  state_d = ST_POST_DLY;
        else               state_d = ST_WAIT_RES;
      end
      ST_POST_DLY: begin
        if (i_abort)         state_d = ST_IDLE;
        else if (post_hit_s) state_d = last_run_s ? ST_FINISH : ST_START;
        else                 state_d = ST_POST_DLY;
      end
      ST_FINISH:    state_d = i_enable ? ST_FINISH : ST_IDLE;
      ST_DRAIN: begin
        if (i_ap_idle)     state_d = ST_IDLE;
        else if (wd_hit_s) state_d = ST_ERR;
        else               state_d = ST_DRAIN;
      end
      ST_ERR:       state_d = i_enable ? ST_ERR : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign res_fire_s = (state_q == ST_WAIT_RES) && (state_d == ST_POST_DLY);
  assign lat_clr_s  = (state_d == ST_START) && (state_q != ST_START);
  assign lat_run_s  = state_q inside {ST_START, ST_WAIT_DONE};
  assign lat_cap_s  = (state_d == ST_WAIT_RES) && (state_q != ST_WAIT_RES);

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    tmr_d      = (state_d != state_q) ? 32'd0 : (tmr_run_s ? tmr_q + 32'd1 : tmr_q);
    run_d      = sess_start_s ? 16'd0 : (res_fire_s ? run_q + 16'd1 : run_q);
    res_v_d    = res_fire_s;
    res_lbl_d  = res_fire_s ? i_max_lbl : res_lbl_q;
    res_idx_d  = res_fire_s ? run_q : res_idx_q;
    ap_start_d = (state_d == ST_START);
    busy_d     = state_d inside {ST_PRE_DLY, ST_START, ST_WAIT_DONE,
                                 ST_WAIT_RES, ST_POST_DLY, ST_DRAIN};
    done_d     = sess_start_s ? 1'b0 : ((state_d == ST_FINISH) ? 1'b1 : done_q);
    timeout_d  = sess_start_s ? 1'b0 : ((state_d == ST_ERR) ? 1'b1 : timeout_q);
  end

  // Sequencer state and output registers; en_prev resets high so a held enable cannot restart.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state_q    <= ST_IDLE;
      en_prev_q  <= 1'b1;
      tmr_q      <= 32'd0;
      run_q      <= 16'd0;
      res_v_q    <= 1'b0;
      res_lbl_q  <= {LBL_W{1'b0}};
      res_idx_q  <= 16'd0;
      ap_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= i_enable;
      tmr_q      <= tmr_d;
      run_q      <= run_d;
      res_v_q    <= res_v_d;
      res_lbl_q  <= res_lbl_d;
      res_idx_q  <= res_idx_d;
      ap_start_q <= ap_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  dnn_lat_stats u_lat_stats (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .sess_clr_i (sess_start_s),
    .cnt_clr_i  (lat_clr_s),
    .run_i      (lat_run_s),
    .capture_i  (lat_cap_s),
    .last_o     (o_last_lat),
    .min_o      (o_min_lat),
    .max_o      (o_max_lat)
  );

  assign o_ap_start = ap_start_q;
  assign o_res_v    = res_v_q;
  assign o_res_lbl  = res_lbl_q;
  assign o_res_idx  = res_idx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_dnn_run_sequencer.sv
// Scoreboard bench for dnn_run_sequencer: randomized accelerator timing, expected
// results queued at stimulus time and checked by an independent output monitor.
module tb_dnn_run_sequencer;

  localparam int unsigned START_DELAY = 4;
  localparam int unsigned END_DELAY   = 3;
  localparam int unsigned NUM_RUNS    = 3;
  localparam int unsigned TIMEOUT     = 50;
  localparam int unsigned LBL_W       = 5;

  logic aclk = 1'b0, aresetn = 1'b1;
  logic i_enable = 1'b0, i_abort = 1'b0, i_ap_ready = 1'b0, i_ap_done = 1'b0;
  logic i_ap_idle = 1'b1, i_max_v = 1'b0;
  logic [LBL_W-1:0] i_max_lbl = 5'd0;
  logic o_ap_start, o_res_v, o_busy, o_done, o_timeout;
  logic [LBL_W-1:0] o_res_lbl;
  logic [15:0] o_res_idx;
  logic [31:0] o_last_lat, o_min_lat, o_max_lat;

  always #5 aclk = ~aclk;

  dnn_run_sequencer #(
    .START_DELAY(START_DELAY), .END_DELAY(END_DELAY), .NUM_RUNS(NUM_RUNS),
    .TIMEOUT(TIMEOUT), .LBL_W(LBL_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .i_enable(i_enable), .i_abort(i_abort),
    .o_ap_start(o_ap_start), .i_ap_ready(i_ap_ready), .i_ap_done(i_ap_done),
    .i_ap_idle(i_ap_idle), .i_max_v(i_max_v), .i_max_lbl(i_max_lbl),
    .o_res_v(o_res_v), .o_res_lbl(o_res_lbl), .o_res_idx(o_res_idx),
    .o_last_lat(o_last_lat), .o_min_lat(o_min_lat), .o_max_lat(o_max_lat),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  typedef struct {
    logic [4:0]  lbl;
    logic [15:0] idx;
    logic [31:0] last;
    logic [31:0] mn;
    logic [31:0] mx;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int st_rise = 0, st_high = 0;
  logic st_prev = 1'b0;
  logic [31:0] mdl_min, mdl_max;
  int mdl_idx;
  int pr[3], pd[3], pm[3], pl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Monitor: counts ap_start activity and checks every result pulse against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (o_ap_start === 1'b1) begin
        st_high++;
        if (st_prev !== 1'b1) st_rise++;
      end
      st_prev = o_ap_start;
      if (o_res_v === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", {31'd0, o_res_v}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_lbl", {27'd0, o_res_lbl}, {27'd0, e.lbl});
          chk("res_idx", {16'd0, o_res_idx}, {16'd0, e.idx});
          chk("res_last_lat", o_last_lat, e.last);
          chk("res_min_lat", o_min_lat, e.mn);
          chk("res_max_lat", o_max_lat, e.mx);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ap_start"}, {31'd0, o_ap_start}, 32'd0);
    chk({tag, "_res_v"}, {31'd0, o_res_v}, 32'd0);
    chk({tag, "_res_lbl"}, {27'd0, o_res_lbl}, 32'd0);
    chk({tag, "_res_idx"}, {16'd0, o_res_idx}, 32'd0);
    chk({tag, "_last_lat"}, o_last_lat, 32'd0);
    chk({tag, "_min_lat"}, o_min_lat, 32'hFFFF_FFFF);
    chk({tag, "_max_lat"}, o_max_lat, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
  endtask

  // Rising enable, then first ap_start expected START_DELAY cycles after busy rises.
  task automatic start_session();
    int k = 0;
    i_enable = 1'b0;
    tick(2);
    i_enable = 1'b1;
    tick(1);
    mdl_min = 32'hFFFF_FFFF;
    mdl_max = 32'd0;
    mdl_idx = 0;
    chk("sess_busy", {31'd0, o_busy}, 32'd1);
    chk("sess_done_clr", {31'd0, o_done}, 32'd0);
    chk("sess_timeout_clr", {31'd0, o_timeout}, 32'd0);
    chk("sess_min_clr", o_min_lat, 32'hFFFF_FFFF);
    chk("sess_max_clr", o_max_lat, 32'd0);
    while (o_ap_start !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    chk("pre_delay", k, START_DELAY);
  endtask

  // Accelerator model for one run: ready r cycles into start, done d cycles later, result m later.
  task automatic run_one(input int r, input int d, input int m, input logic [4:0] lbl);
    int k = 0;
    logic [31:0] lat;
    exp_t e;
    while (o_ap_start !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    chk("start_seen", {31'd0, o_ap_start}, 32'd1);
    if (r > 0) tick(r);
    i_ap_ready = 1'b1;
    i_ap_done  = (d == 0);
    tick(1);
    i_ap_ready = 1'b0;
    i_ap_done  = 1'b0;
    chk("start_dropped", {31'd0, o_ap_start}, 32'd0);
    if (d > 0) begin
      if (d > 1) tick(d - 1);
      i_ap_done = 1'b1;
      tick(1);
      i_ap_done = 1'b0;
    end
    lat = 32'(r + d + 1);
    chk("last_lat", o_last_lat, lat);
    if (lat < mdl_min) mdl_min = lat;
    if (lat > mdl_max) mdl_max = lat;
    if (m > 0) tick(m);
    e.lbl = lbl; e.idx = 16'(mdl_idx); e.last = lat; e.mn = mdl_min; e.mx = mdl_max;
    exp_q.push_back(e);
    i_max_v   = 1'b1;
    i_max_lbl = lbl;
    tick(1);
    i_max_v = 1'b0;
    mdl_idx++;
  endtask

  task automatic run_session();
    int r0 = st_rise;
    int h0 = st_high;
    int hs = 0;
    int k = 0;
    start_session();
    for (int i = 0; i < int'(NUM_RUNS); i++) begin
      run_one(pr[i], pd[i], pm[i], 5'(pl[i]));
      hs += pr[i] + 1;
    end
    while (o_done !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk("sess_done", {31'd0, o_done}, 32'd1);
    chk("sess_busy_off", {31'd0, o_busy}, 32'd0);
    chk("start_pulses", 32'(st_rise - r0), NUM_RUNS);
    chk("start_cycles", 32'(st_high - h0), 32'(hs));
    i_enable = 1'b0;
    tick(2);
    chk("done_sticky", {31'd0, o_done}, 32'd1);
  endtask

  task automatic randomize_runs();
    for (int i = 0; i < 3; i++) begin
      pr[i] = int'($urandom_range(8, 0));
      pd[i] = int'($urandom_range(35, 0));
      pm[i] = int'($urandom_range(10, 0));
      pl[i] = int'($urandom_range(31, 0));
    end
  endtask

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int k;
    int r0;
    tick(3);
    check_reset_vals("rst");
    aresetn = 1'b0;
    tick(2);

    // Latencies 10/30/20.
    pr = '{2, 2, 2}; pd = '{7, 27, 17}; pm = '{1, 4, 2}; pl = '{3, 9, 20};
    run_session();
    chk("s1_min", o_min_lat, 32'd10);
    chk("s1_max", o_max_lat, 32'd30);
    chk("s1_last", o_last_lat, 32'd20);

    // Ready two cycles in with done 20 later, then same-cycle ready/done.
    randomize_runs();
    pr[0] = 2; pd[0] = 20; pm[0] = 5; pl[0] = 7;
    pr[1] = 0; pd[1] = 0;
    run_session();

    for (int s = 0; s < 4; s++) begin
      randomize_runs();
      run_session();
    end

    // Watchdog: done never arrives.
    start_session();
    tick(2);
    i_ap_ready = 1'b1;
    tick(1);
    i_ap_ready = 1'b0;
    k = 0;
    while (o_timeout !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    chk("wd_cycles", k, TIMEOUT);
    chk("wd_ap_start", {31'd0, o_ap_start}, 32'd0);
    chk("wd_busy", {31'd0, o_busy}, 32'd0);
    i_enable = 1'b0;
    tick(2);
    chk("wd_sticky", {31'd0, o_timeout}, 32'd1);

    // Abort in WAIT_DONE with idle low for eight cycles.
    start_session();
    tick(1);
    i_ap_ready = 1'b1;
    tick(1);
    i_ap_ready = 1'b0;
    tick(3);
    i_abort   = 1'b1;
    i_ap_idle = 1'b0;
    tick(1);
    i_abort = 1'b0;
    chk("abort_ap_start", {31'd0, o_ap_start}, 32'd0);
    chk("abort_busy_drain", {31'd0, o_busy}, 32'd1);
    tick(7);
    chk("abort_busy_last", {31'd0, o_busy}, 32'd1);
    i_ap_idle = 1'b1;
    tick(1);
    chk("abort_busy_off", {31'd0, o_busy}, 32'd0);
    tick(2);
    i_max_v   = 1'b1;
    i_max_lbl = 5'd17;
    tick(1);
    i_max_v = 1'b0;
    tick(3);
    chk("abort_no_done", {31'd0, o_done}, 32'd0);

    // Reset pulse in WAIT_RES with enable held high.
    start_session();
    i_ap_ready = 1'b1;
    i_ap_done  = 1'b1;
    tick(1);
    i_ap_ready = 1'b0;
    i_ap_done  = 1'b0;
    tick(2);
    aresetn = 1'b1;
    #2;
    check_reset_vals("midrst");
    tick(1);
    aresetn = 1'b0;
    r0 = st_rise;
    tick(int'(START_DELAY) + 10);
    chk("no_restart_pulses", 32'(st_rise - r0), 32'd0);
    chk("no_restart_busy", {31'd0, o_busy}, 32'd0);

    randomize_runs();
    run_session();

    tick(3);
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
